// File: rtl/result_checker.sv
// Receive-side checker for the arithmetic test loop: aligns a golden model to the measured DUT latency and scores results.
// Optional macro ERR_CAPTURE_EN records operands/expected/actual of the first mismatching cycle.
module result_checker #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OP        = 0,
    parameter int unsigned MAX_DELAY = 15,
    parameter int unsigned NUM_TESTS = 1024
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [WIDTH-1:0] i_dut_out,
    input  logic [31:0]      i_dut_delay,
    output logic [31:0]      o_test_count,
    output logic [31:0]      o_err_count,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_bad_delay,
    output logic [WIDTH-1:0] o_first_err_a,
    output logic [WIDTH-1:0] o_first_err_b,
    output logic [WIDTH-1:0] o_first_err_exp,
    output logic [WIDTH-1:0] o_first_err_got
);

    localparam int unsigned IDX_W         = $clog2(MAX_DELAY + 1);
    localparam logic [31:0] DELAY_UNKNOWN = 32'hFFFF_FFFF;
    localparam logic [31:0] LAST_TEST     = 32'(NUM_TESTS - 1);

    typedef enum logic [2:0] {ST_WAIT, ST_FLUSH, ST_CHECK, ST_DONE, ST_BADDLY} state_t;

    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (OP)
            1:       return a - b;
            2:       return a * b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   delay_q, delay_d;
    logic [IDX_W-1:0]   flush_q, flush_d;
    logic [31:0]        tcnt_q, tcnt_d;
    logic [31:0]        ecnt_q, ecnt_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               bad_q, bad_d;
    logic [WIDTH-1:0]   exp_q [MAX_DELAY];
    logic [WIDTH-1:0]   cmp_exp_c;
    logic               mismatch_c;

    // Expected-value pipe runs free; only the tap at the latched latency matters.
    always_ff @(posedge clk_dut) begin
        exp_q[0] <= golden(i_op_a, i_op_b);
        for (int k = 1; k < int'(MAX_DELAY); k++) exp_q[k] <= exp_q[k-1];
    end

`ifdef ERR_CAPTURE_EN
    logic [WIDTH-1:0] a_q [MAX_DELAY];
    logic [WIDTH-1:0] b_q [MAX_DELAY];
    logic [WIDTH-1:0] cmp_a_c, cmp_b_c;
    logic [WIDTH-1:0] fe_a_q, fe_a_d, fe_b_q, fe_b_d, fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

    always_ff @(posedge clk_dut) begin
        a_q[0] <= i_op_a;
        b_q[0] <= i_op_b;
        for (int k = 1; k < int'(MAX_DELAY); k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
        end
    end

    assign o_first_err_a   = fe_a_q;
    assign o_first_err_b   = fe_b_q;
    assign o_first_err_exp = fe_exp_q;
    assign o_first_err_got = fe_got_q;
`else
    assign o_first_err_a   = '0;
    assign o_first_err_b   = '0;
    assign o_first_err_exp = '0;
    assign o_first_err_got = '0;
`endif

    // Latency 0 compares against the live operands; otherwise tap exp[D-1].
    always_comb begin
        cmp_exp_c = golden(i_op_a, i_op_b);
`ifdef ERR_CAPTURE_EN
        cmp_a_c = i_op_a;
        cmp_b_c = i_op_b;
`endif
        for (int k = 0; k < int'(MAX_DELAY); k++) begin
            if (delay_q == IDX_W'(k + 1)) begin
                cmp_exp_c = exp_q[k];
`ifdef ERR_CAPTURE_EN
                cmp_a_c = a_q[k];
                cmp_b_c = b_q[k];
`endif
            end
        end
        mismatch_c = (i_dut_out != cmp_exp_c);
    end

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        flush_d = flush_q;
        tcnt_d  = tcnt_q;
        ecnt_d  = ecnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        bad_d   = bad_q;
`ifdef ERR_CAPTURE_EN
        fe_a_d   = fe_a_q;
        fe_b_d   = fe_b_q;
        fe_exp_d = fe_exp_q;
        fe_got_d = fe_got_q;
`endif
        case (state_q)
            ST_WAIT: begin
                if (i_dut_delay != DELAY_UNKNOWN) begin
                    if (i_dut_delay > 32'(MAX_DELAY)) begin
                        state_d = ST_BADDLY;
                        bad_d   = 1'b1;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end else begin
                        state_d = ST_FLUSH;
                        delay_d = IDX_W'(i_dut_delay);
                        flush_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == delay_q) state_d = ST_CHECK;
                else                    flush_d = flush_q + IDX_W'(1);
            end
            ST_CHECK: begin
                tcnt_d = sat_inc(tcnt_q);
                if (mismatch_c) begin
                    ecnt_d = sat_inc(ecnt_q);
`ifdef ERR_CAPTURE_EN
                    if (ecnt_q == 32'd0) begin
                        fe_a_d   = cmp_a_c;
                        fe_b_d   = cmp_b_c;
                        fe_exp_d = cmp_exp_c;
                        fe_got_d = i_dut_out;
                    end
`endif
                end
                if (tcnt_q == LAST_TEST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (ecnt_d == 32'd0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            state_q <= ST_WAIT;
            delay_q <= '0;
            flush_q <= '0;
            tcnt_q  <= '0;
            ecnt_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            bad_q   <= 1'b0;
`ifdef ERR_CAPTURE_EN
            fe_a_q   <= '0;
            fe_b_q   <= '0;
            fe_exp_q <= '0;
            fe_got_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            flush_q <= flush_d;
            tcnt_q  <= tcnt_d;
            ecnt_q  <= ecnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            bad_q   <= bad_d;
`ifdef ERR_CAPTURE_EN
            fe_a_q   <= fe_a_d;
            fe_b_q   <= fe_b_d;
            fe_exp_q <= fe_exp_d;
            fe_got_q <= fe_got_d;
`endif
        end
    end

    assign o_test_count = tcnt_q;
    assign o_err_count  = ecnt_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_bad_delay  = bad_q;

endmodule
